// File: rtl/exe_stage_pkg.sv
// Shared ARM pipeline definitions: ALU command codes, forwarding selects,
// shift types and the NZCV flag layout used by the execute stage.
package arm_defs;

   localparam logic [3:0] EXE_CMD_MOV = 4'b0001;
   localparam logic [3:0] EXE_CMD_MVN = 4'b1001;
   localparam logic [3:0] EXE_CMD_ADD = 4'b0010;
   localparam logic [3:0] EXE_CMD_ADC = 4'b0011;
   localparam logic [3:0] EXE_CMD_SUB = 4'b0100;
   localparam logic [3:0] EXE_CMD_SBC = 4'b0101;
   localparam logic [3:0] EXE_CMD_AND = 4'b0110;
   localparam logic [3:0] EXE_CMD_ORR = 4'b0111;
   localparam logic [3:0] EXE_CMD_EOR = 4'b1000;

   localparam logic [1:0] FORW_SEL_ID  = 2'b00;
   localparam logic [1:0] FORW_SEL_WB  = 2'b01;
   localparam logic [1:0] FORW_SEL_MEM = 2'b10;

   typedef enum logic [1:0] {
      SHIFT_LSL = 2'b00,
      SHIFT_LSR = 2'b01,
      SHIFT_ASR = 2'b10,
      SHIFT_ROR = 2'b11
   } shift_type_t;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } nzcv_t;

   // Shifting a 32-bit value by 32 yields zero, so amt=0 returns v unchanged.
   function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] amt);
      return (v >> amt) | (v << (6'd32 - {1'b0, amt}));
   endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EXE-to-EXE/MEM signal bundle of the execute stage. The ID/hazard side
// drives through master; exe_stage consumes through slave.
interface exe_stage_if;
   logic        freeze;
   logic [1:0]  sel_src1;
   logic [1:0]  sel_src2;
   logic [31:0] val_rn;
   logic [31:0] val_rm;
   logic [31:0] MEM_alu_res;
   logic [31:0] WB_value;
   logic [31:0] pc;
   logic [3:0]  exe_cmd;
   logic        mem_r_en;
   logic        mem_w_en;
   logic        wb_en;
   logic        s;
   logic        b;
   logic        imm;
   logic [11:0] shift_operand;
   logic [23:0] signed_imm_24;
   logic [3:0]  dest;

   logic [3:0]  status;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic [31:0] EXE_alu_res;
   logic [31:0] EXE_st_val;
   logic [3:0]  EXE_dst;
   logic        EXE_wb_en;
   logic        EXE_mem_r_en;
   logic        EXE_mem_w_en;

   modport master (
      output freeze, sel_src1, sel_src2, val_rn, val_rm, MEM_alu_res, WB_value,
             pc, exe_cmd, mem_r_en, mem_w_en, wb_en, s, b, imm,
             shift_operand, signed_imm_24, dest,
      input  status, branch_taken, branch_addr, EXE_alu_res, EXE_st_val,
             EXE_dst, EXE_wb_en, EXE_mem_r_en, EXE_mem_w_en
   );

   modport slave (
      input  freeze, sel_src1, sel_src2, val_rn, val_rm, MEM_alu_res, WB_value,
             pc, exe_cmd, mem_r_en, mem_w_en, wb_en, s, b, imm,
             shift_operand, signed_imm_24, dest,
      output status, branch_taken, branch_addr, EXE_alu_res, EXE_st_val,
             EXE_dst, EXE_wb_en, EXE_mem_r_en, EXE_mem_w_en
   );
endinterface

// File: rtl/exe_stage_val2_generator.sv
// Shifter operand (val2) generation: memory offset, rotated immediate or
// shifted register, purely combinational.
module val2_generator
   import arm_defs::*;
(
   input  logic [11:0] shift_operand,
   input  logic        imm,
   input  logic        mem_op,
   input  logic [31:0] rm,
   output logic [31:0] val2
);

   logic [4:0]         imm_rot;
   logic [4:0]         shift_amt;
   shift_type_t        shift_type;
   logic signed [31:0] rm_s;

   assign imm_rot    = {shift_operand[11:8], 1'b0};
   assign shift_amt  = shift_operand[11:7];
   assign shift_type = shift_type_t'(shift_operand[6:5]);
   assign rm_s       = rm;

   // Memory ops win over imm: LDR/STR offsets are raw 12-bit values.
   always_comb begin
      val2 = rm;
      if (mem_op) begin
         val2 = {20'b0, shift_operand};
      end else if (imm) begin
         val2 = ror32({24'b0, shift_operand[7:0]}, imm_rot);
      end else begin
         case (shift_type)
            SHIFT_LSL: val2 = rm << shift_amt;
            SHIFT_LSR: val2 = rm >> shift_amt;
            SHIFT_ASR: val2 = rm_s >>> shift_amt;
            SHIFT_ROR: val2 = ror32(rm, shift_amt);
            default:   val2 = rm;
         endcase
      end
   end

endmodule

// File: rtl/exe_stage.sv
// ARM execute stage: operand forwarding, val2, ALU with NZCV, branch target,
// the status register and the EXE/MEM pipeline register.
module exe_stage
   import arm_defs::*;
(
   input  logic       clk,
   input  logic       rst,
   exe_stage_if.slave ex
);

   logic [31:0] op1_p0;
   logic [31:0] rm_fwd_p0;
   logic [31:0] val2_p0;
   logic        mem_op_p0;
   logic [32:0] wide_p0;
   logic [31:0] alu_res_p0;
   logic        c_new_p0;
   logic        v_new_p0;
   nzcv_t       nzcv_p0;

   nzcv_t       status_p1;
   logic [31:0] alu_res_p1;
   logic [31:0] st_val_p1;
   logic [3:0]  dst_p1;
   logic        wb_en_p1;
   logic        mem_r_en_p1;
   logic        mem_w_en_p1;

   function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                           input logic [31:0] id_val,
                                           input logic [31:0] mem_val,
                                           input logic [31:0] wb_val);
      case (sel)
         FORW_SEL_WB:  return wb_val;
         FORW_SEL_MEM: return mem_val;
         default:      return id_val;
      endcase
   endfunction

   // ---- p0: operand selection and shifter operand ----
   assign op1_p0    = fwd_mux(ex.sel_src1, ex.val_rn, ex.MEM_alu_res, ex.WB_value);
   assign rm_fwd_p0 = fwd_mux(ex.sel_src2, ex.val_rm, ex.MEM_alu_res, ex.WB_value);
   assign mem_op_p0 = ex.mem_r_en | ex.mem_w_en;

   val2_generator u_val2_generator (
      .shift_operand (ex.shift_operand),
      .imm           (ex.imm),
      .mem_op        (mem_op_p0),
      .rm            (rm_fwd_p0),
      .val2          (val2_p0)
   );

   // ---- p0: ALU and flag generation ----
   // Logic ops, MOV, MVN and unknown codes keep the previous C and V.
   always_comb begin
      wide_p0    = '0;
      alu_res_p0 = '0;
      c_new_p0   = status_p1.c;
      v_new_p0   = status_p1.v;
      case (ex.exe_cmd)
         EXE_CMD_MOV: alu_res_p0 = val2_p0;
         EXE_CMD_MVN: alu_res_p0 = ~val2_p0;
         EXE_CMD_ADD, EXE_CMD_ADC: begin
            wide_p0    = {1'b0, op1_p0} + {1'b0, val2_p0}
                       + {32'b0, (ex.exe_cmd == EXE_CMD_ADC) & status_p1.c};
            alu_res_p0 = wide_p0[31:0];
            c_new_p0   = wide_p0[32];
            v_new_p0   = (op1_p0[31] == val2_p0[31]) & (alu_res_p0[31] != op1_p0[31]);
         end
         EXE_CMD_SUB, EXE_CMD_SBC: begin
            wide_p0    = {1'b0, op1_p0} - {1'b0, val2_p0}
                       - {32'b0, (ex.exe_cmd == EXE_CMD_SBC) & ~status_p1.c};
            alu_res_p0 = wide_p0[31:0];
            c_new_p0   = ~wide_p0[32];
            v_new_p0   = (op1_p0[31] != val2_p0[31]) & (alu_res_p0[31] != op1_p0[31]);
         end
         EXE_CMD_AND: alu_res_p0 = op1_p0 & val2_p0;
         EXE_CMD_ORR: alu_res_p0 = op1_p0 | val2_p0;
         EXE_CMD_EOR: alu_res_p0 = op1_p0 ^ val2_p0;
         default:     alu_res_p0 = '0;
      endcase
      nzcv_p0.n = alu_res_p0[31];
      nzcv_p0.z = (alu_res_p0 == 32'd0);
      nzcv_p0.c = c_new_p0;
      nzcv_p0.v = v_new_p0;
   end

   assign ex.branch_taken = ex.b;
   assign ex.branch_addr  = ex.pc + {{6{ex.signed_imm_24[23]}}, ex.signed_imm_24, 2'b00};

   // ---- p1: status register ----
   // A setter caught by freeze is dropped; it re-executes after the release.
   always_ff @(posedge clk) begin
      if (rst) begin
         status_p1 <= '0;
      end else if (!ex.freeze && ex.s) begin
         status_p1 <= nzcv_p0;
      end
   end

   // ---- p1: EXE/MEM pipeline register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_res_p1  <= '0;
         st_val_p1   <= '0;
         dst_p1      <= '0;
         wb_en_p1    <= 1'b0;
         mem_r_en_p1 <= 1'b0;
         mem_w_en_p1 <= 1'b0;
      end else if (!ex.freeze) begin
         alu_res_p1  <= alu_res_p0;
         st_val_p1   <= rm_fwd_p0;
         dst_p1      <= ex.dest;
         wb_en_p1    <= ex.wb_en;
         mem_r_en_p1 <= ex.mem_r_en;
         mem_w_en_p1 <= ex.mem_w_en;
      end
   end

   assign ex.status       = status_p1;
   assign ex.EXE_alu_res  = alu_res_p1;
   assign ex.EXE_st_val   = st_val_p1;
   assign ex.EXE_dst      = dst_p1;
   assign ex.EXE_wb_en    = wb_en_p1;
   assign ex.EXE_mem_r_en = mem_r_en_p1;
   assign ex.EXE_mem_w_en = mem_w_en_p1;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: vector table through a scoreboard queue,
// plus hand-written freeze, reset and branch sequences.
module tb_exe_stage;
   import arm_defs::*;

   typedef struct {
      logic [1:0]  sel1;
      logic [1:0]  sel2;
      logic [31:0] rn;
      logic [31:0] rm;
      logic [3:0]  cmd;
      logic        mr;
      logic        mw;
      logic        wb;
      logic        s;
      logic        imm;
      logic [11:0] so;
      logic [3:0]  dst;
      logic [31:0] e_res;
      logic [31:0] e_st;
      logic [3:0]  e_status;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [31:0] st;
      logic [3:0]  status;
      logic [3:0]  dst;
      logic [2:0]  ctrl;
   } exp_t;

   localparam int NVEC = 19;

   logic  clk = 1'b0;
   logic  rst;
   int    checks = 0;
   int    errors = 0;
   vec_t  tbl [NVEC];
   exp_t  sb_q [$];

   exe_stage_if ex_if ();

   exe_stage dut (
      .clk (clk),
      .rst (rst),
      .ex  (ex_if)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      ex_if.freeze        = 1'b0;
      ex_if.sel_src1      = v.sel1;
      ex_if.sel_src2      = v.sel2;
      ex_if.val_rn        = v.rn;
      ex_if.val_rm        = v.rm;
      ex_if.MEM_alu_res   = 32'h0000_0005;
      ex_if.WB_value      = 32'h0000_DEAD;
      ex_if.pc            = 32'h0000_0000;
      ex_if.exe_cmd       = v.cmd;
      ex_if.mem_r_en      = v.mr;
      ex_if.mem_w_en      = v.mw;
      ex_if.wb_en         = v.wb;
      ex_if.s             = v.s;
      ex_if.b             = 1'b0;
      ex_if.imm           = v.imm;
      ex_if.shift_operand = v.so;
      ex_if.signed_imm_24 = 24'h0;
      ex_if.dest          = v.dst;
   endtask

   task automatic push_exp(input logic [31:0] res, input logic [31:0] st, input logic [3:0] status,
                           input logic [3:0] dst, input logic [2:0] ctrl);
      exp_t e;
      e.res = res; e.st = st; e.status = status; e.dst = dst; e.ctrl = ctrl;
      sb_q.push_back(e);
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty, got res %h", tag, ex_if.EXE_alu_res);
         return;
      end
      e = sb_q.pop_front();
      chk({tag, ".res"},    ex_if.EXE_alu_res, e.res);
      chk({tag, ".st_val"}, ex_if.EXE_st_val, e.st);
      chk({tag, ".status"}, 32'(ex_if.status), 32'(e.status));
      chk({tag, ".dst"},    32'(ex_if.EXE_dst), 32'(e.dst));
      chk({tag, ".ctrl"},   32'({ex_if.EXE_wb_en, ex_if.EXE_mem_r_en, ex_if.EXE_mem_w_en}), 32'(e.ctrl));
   endtask

   initial begin
      vec_t v;

      //          sel1  sel2  rn             rm             cmd          mr    mw    wb    s     imm   so       dst   res            st_val         NZCV
      tbl[0]  = '{2'd2, 2'd0, 32'd99,        32'd0,         EXE_CMD_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h003, 4'd1, 32'h0000_0008, 32'h0,         4'b0000};
      tbl[1]  = '{2'd0, 2'd0, 32'd0,         32'd0,         EXE_CMD_MOV, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h1FF, 4'd2, 32'hC000_003F, 32'h0,         4'b0000};
      tbl[2]  = '{2'd0, 2'd0, 32'd3,         32'd0,         EXE_CMD_SUB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h005, 4'd3, 32'hFFFF_FFFE, 32'h0,         4'b1000};
      tbl[3]  = '{2'd0, 2'd0, 32'd5,         32'd0,         EXE_CMD_SUB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h005, 4'd0, 32'h0000_0000, 32'h0,         4'b0110};
      tbl[4]  = '{2'd0, 2'd0, 32'd1,         32'd0,         EXE_CMD_ADC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h001, 4'd4, 32'h0000_0003, 32'h0,         4'b0000};
      tbl[5]  = '{2'd0, 2'd0, 32'h7FFF_FFFF, 32'd0,         EXE_CMD_ADD, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h001, 4'd5, 32'h8000_0000, 32'h0,         4'b1001};
      tbl[6]  = '{2'd0, 2'd0, 32'd10,        32'd0,         EXE_CMD_SBC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h003, 4'd6, 32'h0000_0006, 32'h0,         4'b0010};
      tbl[7]  = '{2'd0, 2'd0, 32'd0,         32'h0000_000F, EXE_CMD_MOV, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h200, 4'd7, 32'h0000_00F0, 32'h0000_000F, 4'b0010};
      tbl[8]  = '{2'd0, 2'd0, 32'd0,         32'h8000_0000, EXE_CMD_MOV, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h220, 4'd8, 32'h0800_0000, 32'h8000_0000, 4'b0010};
      tbl[9]  = '{2'd0, 2'd0, 32'd0,         32'h8000_0000, EXE_CMD_MOV, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h240, 4'd9, 32'hF800_0000, 32'h8000_0000, 4'b1010};
      tbl[10] = '{2'd0, 2'd0, 32'd0,         32'h0000_00F1, EXE_CMD_MOV, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h260, 4'd10, 32'h1000_000F, 32'h0000_00F1, 4'b1010};
      tbl[11] = '{2'd0, 2'd0, 32'd0,         32'd0,         EXE_CMD_MVN, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000, 4'd11, 32'hFFFF_FFFF, 32'h0,        4'b1010};
      tbl[12] = '{2'd0, 2'd0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, EXE_CMD_AND, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 4'd12, 32'h0000_0000, 32'h0F0F_0F0F, 4'b0110};
      tbl[13] = '{2'd0, 2'd0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, EXE_CMD_ORR, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 4'd13, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 4'b0110};
      tbl[14] = '{2'd0, 2'd0, 32'hFF00_FF00, 32'hFFFF_0000, EXE_CMD_EOR, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 4'd14, 32'h00FF_FF00, 32'hFFFF_0000, 4'b0110};
      tbl[15] = '{2'd0, 2'd0, 32'd5,         32'd0,         4'b0000,     1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h001, 4'd15, 32'h0000_0000, 32'h0,        4'b0110};
      tbl[16] = '{2'd0, 2'd1, 32'h0000_1000, 32'd0,         EXE_CMD_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h1FF, 4'd2, 32'h0000_11FF, 32'h0000_DEAD, 4'b0110};
      tbl[17] = '{2'd1, 2'd2, 32'h0000_1000, 32'd0,         EXE_CMD_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h1FF, 4'd3, 32'h0000_E0AC, 32'h0000_0005, 4'b0110};
      tbl[18] = '{2'd3, 2'd3, 32'h0000_0020, 32'h0000_0030, EXE_CMD_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 4'd4, 32'h0000_0050, 32'h0000_0030, 4'b0110};

      // Reset state
      v = tbl[0];
      drive(v);
      ex_if.wb_en = 1'b0;
      rst = 1'b1;
      step();
      step();
      push_exp(32'h0, 32'h0, 4'b0000, 4'd0, 3'b000);
      pop_check("reset");
      rst = 1'b0;

      // Vector table through the scoreboard
      for (int i = 0; i < NVEC; i++) begin
         drive(tbl[i]);
         push_exp(tbl[i].e_res, tbl[i].e_st, tbl[i].e_status, tbl[i].dst,
                  {tbl[i].wb, tbl[i].mr, tbl[i].mw});
         step();
         pop_check($sformatf("vec%0d", i));
      end

      // Combinational branch target
      ex_if.b             = 1'b1;
      ex_if.pc            = 32'h0000_0100;
      ex_if.signed_imm_24 = 24'hFFFFFE;
      #1;
      chk("branch_taken", 32'(ex_if.branch_taken), 32'd1);
      chk("branch_back",  ex_if.branch_addr, 32'h0000_00F8);
      ex_if.pc            = 32'h0000_0200;
      ex_if.signed_imm_24 = 24'h000010;
      #1;
      chk("branch_fwd",   ex_if.branch_addr, 32'h0000_0240);
      ex_if.b = 1'b0;
      #1;
      chk("branch_not_taken", 32'(ex_if.branch_taken), 32'd0);

      // Overflowing setter, then freeze for 3 cycles with another setter
      v = tbl[5];
      drive(v);
      push_exp(32'h8000_0000, 32'h0, 4'b1001, 4'd5, 3'b100);
      step();
      pop_check("ovf");
      v = tbl[3];
      v.dst = 4'd9;
      v.mw  = 1'b1;
      drive(v);
      ex_if.freeze = 1'b1;
      for (int k = 0; k < 3; k++) begin
         push_exp(32'h8000_0000, 32'h0, 4'b1001, 4'd5, 3'b100);
         step();
         pop_check($sformatf("freeze%0d", k));
      end
      ex_if.freeze = 1'b0;
      push_exp(32'h0, 32'h0, 4'b0110, 4'd9, 3'b001);
      step();
      pop_check("release");

      // Reset asserted while frozen
      v = tbl[13];
      drive(v);
      ex_if.freeze = 1'b1;
      rst = 1'b1;
      push_exp(32'h0, 32'h0, 4'b0000, 4'd0, 3'b000);
      step();
      pop_check("rst_freeze");
      rst = 1'b0;
      ex_if.freeze = 1'b0;

      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage ARM pipeline, sitting between the ID/EXE register and the MEM stage. It consumes the forwarding unit's `sel_src1`/`sel_src2` to pick operands from ID, MEM or WB. It computes the shifter operand (val2), the ALU result and the NZCV flags, and the branch target. Results are registered into the EXE/MEM pipeline register, and a status register is held internally.

## Interface
Parameters:
- none; widths are fixed (32-bit datapath, 4-bit register index).

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `freeze`  in  1  memory stall; holds the EXE/MEM register and the status register
- `sel_src1`, `sel_src2`  in  2  forwarding select: 00 = ID value, 01 = WB, 10 = MEM, 11 treated as 00
- `val_rn`, `val_rm`  in  32  register-file operands from ID/EXE
- `MEM_alu_res`  in  32  forwarded value from MEM
- `WB_value`  in  32  forwarded value from WB
- `pc`  in  32  PC+4 of this instruction
- `exe_cmd`  in  4  ALU op code
- `mem_r_en`, `mem_w_en`, `wb_en`, `s`, `b`, `imm`  in  1  control bits from ID/EXE
- `shift_operand`  in  12  instruction[11:0]
- `signed_imm_24`  in  24  branch offset
- `dest`  in  4  destination register
- `status`  out  4  NZCV register, consumed by ID condition check
- `branch_taken`  out  1  combinational, equals `b`
- `branch_addr`  out  32  combinational, `pc + (sign_ext(signed_imm_24) << 2)`
- `EXE_alu_res`  out  32  registered
- `EXE_st_val`  out  32  registered; forwarded rm, the store data
- `EXE_dst`  out  4  registered
- `EXE_wb_en`, `EXE_mem_r_en`, `EXE_mem_w_en`  out  1  registered

## Operation
- **Operand selection:** op1 is `val_rn` muxed by `sel_src1`; rm_fwd is `val_rm` muxed by `sel_src2`.
- **val2 when `mem_r_en|mem_w_en`:** zero-extended `shift_operand[11:0]`.
- **val2 when `imm=1`:** `{24'b0, shift_operand[7:0]}` rotated right by `2*shift_operand[11:8]`.
- **val2 otherwise:** rm_fwd shifted by `shift_operand[11:7]`, shift type `[6:5]` (00 LSL, 01 LSR, 10 ASR, 11 ROR). A shift amount of 0 passes the value through unchanged.
- **exe_cmd encodings:**
  - 0001 MOV: res = val2
  - 1001 MVN: res = ~val2
  - 0010 ADD/LDR/STR: res = op1 + val2
  - 0011 ADC: res = op1 + val2 + C
  - 0100 SUB/CMP: res = op1 - val2
  - 0101 SBC: res = op1 - val2 - !C
  - 0110 AND/TST, 0111 ORR, 1000 EOR: bitwise op
  - any other code: res = 0
- **Flags:** computed in 33-bit arithmetic.
  - N = res[31]; Z = (res == 0).
  - Add ops: C = bit 32 carry out.
  - Sub ops: C = NOT borrow, i.e. op1 ≥ val2 unsigned (SBC also accounts for the incoming !C).
  - V = signed overflow of the operation as performed.
  - Logic ops, MOV, MVN: C and V are unchanged.
- **Status register:** loads the new NZCV when `s=1` and `!freeze`; otherwise it holds.
- **CMP/TST:** ID supplies `wb_en=0`; this block does not special-case them.

## Timing
- **Reset (`rst=1` at a rising edge):** every registered output and `status` become 0; this overrides `freeze`.
- **Normal edge (`!freeze`):** the EXE/MEM register captures the current-cycle values, giving a latency of 1 cycle from ID/EXE to `EXE_*`.
- **`freeze=1`:** all `EXE_*` outputs and `status` hold their values.
- **Flags vs. condition check:** a flag update becomes visible on `status` the cycle after the setting instruction is in EXE. Cond-check sees the old flags while the setter is in EXE; the ID stall logic handles this.
- **Combinational outputs:** `branch_taken` and `branch_addr` depend only on current inputs. Flushing upstream registers is the hazard unit's job, not this block's.
- **Simultaneous `s=1` and `freeze=1`:** the flag update is dropped. The instruction re-executes when the freeze releases, so no update is lost.

## Structure
- **Shared package (`arm_defs`):** `EXE_CMD_*` constants, forwarding select constants `FORW_SEL_ID`/`FORW_SEL_WB`/`FORW_SEL_MEM`, and shift-type constants.
- **Sub-module `val2_generator`:** purely combinational; inputs `shift_operand`, `imm`, `mem_op`, `rm`; output `val2`.
- **Rest of the block:** ALU, status register and EXE/MEM register stay in `exe_stage`.

## Test plan
- **Forwarding + ADD:** `sel_src1=10`, `MEM_alu_res=5`, `val_rn=99`, `imm=1`, `shift_operand=12'h003`, `exe_cmd=0010` -> next cycle `EXE_alu_res=8`.
- **Immediate rotate:** `imm=1`, `shift_operand=12'h1FF` (0xFF rotated right by 2), MOV -> `EXE_alu_res=32'hC000003F`.
- **SUB flags:** op1=3, val2=5, `s=1` -> res `32'hFFFFFFFE`, `status=4'b1000` (N=1, C=0). Then op1=5, val2=5 -> `status=4'b0110`.
- **Overflow, then freeze:** ADD with op1 `32'h7FFFFFFF`, val2=1, `s=1` -> `status=4'b1001`. Then hold `freeze=1` for 3 cycles with a new op and `s=1` -> `EXE_*` and `status` unchanged.
- **Store + branch:** STR with `sel_src2=01`, `WB_value=32'hDEAD` -> `EXE_st_val=32'hDEAD`, `EXE_mem_w_en=1`. Branch with `pc=32'h100`, `signed_imm_24=24'hFFFFFE` -> `branch_addr=32'hF8`.
- **Reset mid-stream:** assert `rst` during `freeze` -> all outputs 0 on the next edge.
